// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared sizing constants and core FSM state type for the DCT block controller
package dct_pkg;

    localparam int N_PT     = 8;
    localparam int DATA_W   = 8;
    localparam int COEF_W   = 19;
    localparam int CALC_CYC = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } core_state_t;

endpackage

// File: rtl/dct_sample_buf.sv
// rtl/dct_sample_buf.sv - N_PT x DATA_W sample collect buffer with fill counter
module dct_sample_buf #(
    parameter int N_PT   = dct_pkg::N_PT,
    parameter int DATA_W = dct_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   launch,
    output logic                   in_ready,
    output logic                   full,
    output logic [N_PT*DATA_W-1:0] buf_data
);
    import dct_pkg::*;

    localparam int FILL_W = $clog2(N_PT + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N_PT);

    logic [FILL_W-1:0] fill_cnt;

    assign in_ready = (fill_cnt < FILL_MAX);
    assign full     = (fill_cnt == FILL_MAX);

    // launch only happens when full, so it never coincides with a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            buf_data <= '0;
        end else if (launch) begin
            fill_cnt <= '0;
        end else if (in_valid && in_ready) begin
            for (int k = 0; k < N_PT; k++) begin
                if (fill_cnt == FILL_W'(k)) begin
                    buf_data[k*DATA_W +: DATA_W] <= in_data;
                end
            end
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dct_block_ctrl.sv
// rtl/dct_block_ctrl.sv - collects sample blocks, sequences the DCT datapath and drains coefficients
module dct_block_ctrl #(
    parameter int N_PT     = dct_pkg::N_PT,
    parameter int DATA_W   = dct_pkg::DATA_W,
    parameter int COEF_W   = dct_pkg::COEF_W,
    parameter int CALC_CYC = dct_pkg::CALC_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic [N_PT*DATA_W-1:0] dct_x,
    output logic                   dct_en,
    output logic                   dct_cs,
    output logic                   dct_start,
    input  logic [N_PT*COEF_W-1:0] dct_coef,
    output logic                   out_valid,
    output logic [COEF_W-1:0]      out_data,
    output logic [2:0]             out_idx,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy
);
    import dct_pkg::*;

    localparam int CNT_W = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
    localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(CALC_CYC - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(N_PT - 1);

    core_state_t            state;
    logic [CNT_W-1:0]       calc_cnt;
    logic [N_PT*COEF_W-1:0] coef_reg;
    logic [N_PT*DATA_W-1:0] buf_data;
    logic                   buf_full;
    logic                   launch;

    assign launch = (state == ST_IDLE) && buf_full;

    dct_sample_buf #(
        .N_PT   (N_PT),
        .DATA_W (DATA_W)
    ) u_sample_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .launch   (launch),
        .in_ready (in_ready),
        .full     (buf_full),
        .buf_data (buf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            calc_cnt  <= '0;
            coef_reg  <= '0;
            dct_x     <= '0;
            dct_en    <= 1'b0;
            dct_start <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (buf_full) begin
                        state     <= ST_COMPUTE;
                        dct_x     <= buf_data;
                        calc_cnt  <= '0;
                        dct_en    <= 1'b1;
                        dct_start <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    dct_start <= 1'b0;
                    if (calc_cnt == CALC_LAST) begin
                        coef_reg  <= dct_coef;
                        calc_cnt  <= '0;
                        dct_en    <= 1'b0;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        calc_cnt <= calc_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // out_valid is always high here, so out_ready alone completes a handshake
                    if (out_ready) begin
                        if (out_idx == IDX_LAST) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dct_cs   = dct_en;
    assign busy     = (state != ST_IDLE);
    assign out_last = (out_idx == IDX_LAST);
    assign out_data = coef_reg[int'(out_idx)*COEF_W +: COEF_W];

endmodule

// File: doc/dct_block_ctrl.md
DCT_BLOCK_CTRL -- requirements
Module: dct_block_ctrl

Interface
REQ-001 Parameter N_PT, default 8: samples per DCT block, which is also the number of coefficient zones.
REQ-002 Parameter DATA_W, default 8: signed EEG sample width.
REQ-003 Parameter COEF_W, default 19: signed coefficient width per zone output.
REQ-004 Parameter CALC_CYC, default 10: cycles dct_en is held high per block (datapath compute latency).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  sample valid.
REQ-008 in_data  input  DATA_W  signed sample.
REQ-009 in_ready  output  1  controller can accept a sample.
REQ-010 dct_x  output  N_PT*DATA_W  held block to the datapath; sample k occupies bits [k*DATA_W +: DATA_W].
REQ-011 dct_en  output  1  datapath enable.
REQ-012 dct_cs  output  1  coefficient ROM chip select.
REQ-013 dct_start  output  1  one-cycle pulse that clears the datapath accumulators.
REQ-014 dct_coef  input  N_PT*COEF_W  zone outputs Z1..Z8; zone k occupies bits [k*COEF_W +: COEF_W].
REQ-015 out_valid  output  1  coefficient valid.
REQ-016 out_data  output  COEF_W  signed coefficient.
REQ-017 out_idx  output  3  coefficient index 0..N_PT-1.
REQ-018 out_last  output  1  high with the final coefficient of a block.
REQ-019 out_ready  input  1  downstream (RLE) accepts the coefficient.
REQ-020 busy  output  1  core FSM is not in IDLE.

Function
REQ-021 Collect buffer: a handshake occurs when in_valid and in_ready are both 1; it writes in_data to slot fill_cnt and increments fill_cnt.
REQ-022 in_ready = (fill_cnt < N_PT); once the buffer is full, no sample is accepted until it is launched.
REQ-023 Core FSM states: IDLE, COMPUTE, DRAIN.
REQ-024 IDLE -> COMPUTE when fill_cnt == N_PT; in that cycle the buffer copies to the dct_x hold register and fill_cnt resets to 0.
REQ-025 A sample offered in the launch cycle is not accepted, because in_ready is 0 in that cycle.
REQ-026 dct_x remains stable from launch until the next launch.
REQ-027 In COMPUTE, dct_en = dct_cs = 1 for exactly CALC_CYC cycles, counted by calc_cnt.
REQ-028 dct_start is high only in the first COMPUTE cycle.
REQ-029 On the last COMPUTE cycle, dct_coef is latched into the coefficient register and the FSM moves to DRAIN; dct_en and dct_cs are 0 outside COMPUTE.
REQ-030 In DRAIN, out_valid = 1 and out_data = coefficient[out_idx], starting at out_idx = 0.
REQ-031 Each cycle with out_valid and out_ready both 1 increments out_idx.
REQ-032 out_last = (out_idx == N_PT-1).
REQ-033 While out_ready = 0, out_valid, out_data, out_idx and out_last hold steady.
REQ-034 On the out_last handshake, the FSM moves DRAIN -> IDLE; if the collect buffer is full in that cycle, the next launch occurs in the following cycle, giving one IDLE cycle between blocks.
REQ-035 The collect buffer accepts samples during COMPUTE and DRAIN, overlapping filling with computation.
REQ-036 Coefficients pass through unmodified; there is no saturation or truncation.
REQ-037 Latency from the Nth input handshake to the first out_valid = CALC_CYC + 2 cycles.

Reset
REQ-038 Asserting rst_n low, at any time including mid-COMPUTE or mid-DRAIN, immediately forces: FSM to IDLE, fill_cnt = 0, calc_cnt = 0, out_idx = 0, and dct_x and the coefficient register to zero.
REQ-039 Output values while in reset: in_ready = 1, dct_en = dct_cs = dct_start = 0, out_valid = out_last = 0, out_data = 0, busy = 0.
REQ-040 A partially collected block is discarded on reset.

Structure
REQ-041 The shared dct_pkg holds N_PT, DATA_W, COEF_W, CALC_CYC and the FSM state enum.
REQ-042 The only sub-module is dct_sample_buf, the N_PT x DATA_W collect buffer with its fill counter; the FSM and the drain multiplexer live at top level.

Verification
REQ-043 Feed samples 1..8 back-to-back with out_ready = 1 and a datapath model returning coefficients 100..107 -> dct_x = {8,7,...,1}, dct_start pulses once, dct_en is high for 10 cycles, outputs are 100..107 with idx 0..7, out_last on 107, first out_valid 12 cycles after the 8th sample.
REQ-044 Hold out_ready = 0 for 5 cycles at idx 3 -> out_data stays at coefficient 3 throughout, no index is skipped, and coefficient 3 is emitted exactly once.
REQ-045 Stream 24 continuous samples -> in_ready drops once the second buffer is full, three blocks complete in order, and each block has exactly one out_last.
REQ-046 Assert rst_n low in COMPUTE cycle 4 with 3 samples already buffered -> dct_en = 0 immediately, no out_valid follows, and the next 8 samples form a clean block.
REQ-047 Second block fully buffered when out_last of the first handshakes -> exactly one IDLE cycle, then dct_start; the sample offered in the launch cycle is not accepted.
